// File: rtl/uart_tx_frame_ctrl_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmit frame controller.
//   tx_state_e         : frame FSM states
//   STOP_BITS          : stop-bit cycles per frame; 2 when UART_TX_STOP2_EN is
//                        defined, otherwise 1
//   DEFAULT_DATA_WIDTH : default data bits per frame (legal range 5..9)
package uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// uart_tx_frame_ctrl_if: byte request / serial line bundle for the UART
// transmit frame controller.
//   P_Data     : parallel byte to send
//   Data_Valid : send request (pulse or level)
//   Par_En     : insert parity bit in this frame
//   Par_bit    : parity value from the parity calculator
//   TX_OUT     : serial line, idle high
//   Busy       : frame in progress
// master = requester side, slave = frame controller side.
interface uart_tx_frame_ctrl_if
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] P_Data;
  logic                  Data_Valid;
  logic                  Par_En;
  logic                  Par_bit;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_Data, Data_Valid, Par_En, Par_bit,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_Data, Data_Valid, Par_En, Par_bit,
    output TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_frame_ctrl_serializer.sv
// uart_tx_serializer: load/shift register and bit counter for the data phase.
//   CLK, RST : clock, async active-high reset
//   Load     : capture P_Data, clear counter
//   Ser_En   : data phase active; shift one bit and count per cycle
//   P_Data   : parallel byte
//   Ser_Data : bit the line must carry in the NEXT cycle
//   Ser_Done : last data bit on the line (counter at W-1 while Ser_En)
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Load,
  input  logic                  Ser_En,
  input  logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Ser_Data,
  output logic                  Ser_Done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign Ser_Done = Ser_En && (cnt_q == CNT_LAST);

  // TX_OUT is registered, so the top needs the upcoming bit: d0 before the
  // data phase, then the bit above the one currently on the line.
  assign Ser_Data = Ser_En ? shift_q[1] : shift_q[0];

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (Load) begin
      shift_d = P_Data;
      cnt_d   = '0;
    end else if (Ser_En) begin
      shift_d = shift_q >> 1;
      cnt_d   = Ser_Done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART transmit frame FSM and output register.
// Sends start / data (LSB first) / optional parity / stop on TX_OUT.
//   CLK, RST : clock, async active-high reset
//   bus      : uart_tx_frame_ctrl_if.slave (P_Data, Data_Valid, Par_En,
//              Par_bit in; TX_OUT, Busy out, both registered)
// Build option: UART_TX_STOP2_EN selects two stop bits instead of one.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (low), one cycle
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit captured from Par_bit at DATA exit
// STOP   | line high for STOP_BITS cycles
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input logic                   CLK,
  input logic                   RST,
  uart_tx_frame_ctrl_if.slave   bus
);

  tx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      stop_cnt_q, stop_cnt_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      load, ser_en, ser_data, ser_done;

  assign load   = (state_q == IDLE) && bus.Data_Valid;
  assign ser_en = (state_q == DATA);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .Load     (load),
    .Ser_En   (ser_en),
    .P_Data   (bus.P_Data),
    .Ser_Data (ser_data),
    .Ser_Done (ser_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      par_en_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_en_q   <= par_en_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    par_en_d = load ? bus.Par_En : par_en_q;
    unique case (state_q)
      IDLE:    if (bus.Data_Valid) state_d = START;
      START:   state_d = DATA;
      DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    if (stop_cnt_q == 1'(STOP_BITS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    stop_cnt_d = ((state_q == STOP) && (state_d == STOP)) ? stop_cnt_q + 1'b1 : 1'b0;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state they belong to.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = ser_data;
      PARITY:  tx_d = bus.Par_bit;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
module tb_uart_tx_frame_ctrl;

  localparam int W = 8;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(W)) bus ();
  uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] bits;
    int          len;
    int          gap;
    string       tag;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference frame: list of line levels, one per bit time.
  function automatic frame_t model(logic [W-1:0] d, bit pe, bit pb, int gap, string tag);
    frame_t f;
    int n = 0;
    f.bits = '0;
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < W; i++) begin f.bits[n] = d[i]; n++; end
    if (pe) begin f.bits[n] = pb; n++; end
    for (int i = 0; i < NSTOP; i++) begin f.bits[n] = 1'b1; n++; end
    f.len = n; f.gap = gap; f.tag = tag;
    return f;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit          collecting = 0;
  logic [31:0] act_bits;
  int          act_len;
  int          idle_cnt = 0;
  int          start_gap;

  task automatic finish_frame();
    frame_t f;
    logic [31:0] mask;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'(act_len), 32'(0));
      return;
    end
    f = exp_q.pop_front();
    mask = (32'h1 << f.len) - 1;
    check({f.tag, "_len"}, 32'(act_len), 32'(f.len));
    check({f.tag, "_bits"}, act_bits & mask, f.bits);
    if (f.gap >= 0) check({f.tag, "_gap"}, 32'(start_gap), 32'(f.gap));
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        collecting = 0;
        idle_cnt   = 0;
      end else if (bus.Busy) begin
        if (!collecting) begin
          collecting = 1; act_len = 0; act_bits = '0; start_gap = idle_cnt;
        end
        if (act_len < 32) act_bits[act_len] = bus.TX_OUT;
        act_len++;
        if (act_len == 40) begin
          checks++; errors++;
          $display("FAIL frame_timeout actual=%0d required<=%0d", act_len, 1 + W + 1 + NSTOP);
        end
      end else begin
        check("idle_tx", 32'(bus.TX_OUT), 32'(1));
        if (collecting) begin
          collecting = 0;
          finish_frame();
          idle_cnt = 1;
        end else begin
          idle_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge. mask[c]=1 raises Data_Valid (with scrambled
  // P_Data/Par_En) for the edge c cycles after the accept edge.
  task automatic send(input logic [W-1:0] d, input bit pe, input bit pb,
                      input logic [31:0] mask, input string tag);
    int len = 1 + W + int'(pe) + NSTOP;
    bus.P_Data = d; bus.Par_En = pe; bus.Par_bit = pb; bus.Data_Valid = 1'b1;
    exp_q.push_back(model(d, pe, pb, -1, tag));
    @(negedge CLK);
    for (int c = 1; c <= len + 1; c++) begin
      if (c <= len && mask[c]) begin
        bus.Data_Valid = 1'b1;
        bus.P_Data     = W'($urandom);
        bus.Par_En     = ~pe;
      end else begin
        bus.Data_Valid = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  task automatic send_held(input logic [W-1:0] d1, input logic [W-1:0] d2,
                           input bit pe, input bit pb);
    int len = 1 + W + int'(pe) + NSTOP;
    bus.P_Data = d1; bus.Par_En = pe; bus.Par_bit = pb; bus.Data_Valid = 1'b1;
    exp_q.push_back(model(d1, pe, pb, -1, "held1"));
    exp_q.push_back(model(d2, pe, pb, 1, "held2"));
    repeat (3) @(negedge CLK);
    bus.P_Data = d2;
    repeat (len - 1) @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (len + 1) @(negedge CLK);
  endtask

  initial begin
    bus.P_Data = '0; bus.Data_Valid = 1'b0; bus.Par_En = 1'b0; bus.Par_bit = 1'b0;

    // reset with no clock edge in between
    #2 RST = 1'b1;
    #1;
    check("rst_tx", 32'(bus.TX_OUT), 32'(1));
    check("rst_busy", 32'(bus.Busy), 32'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    send(8'hA5, 1'b0, 1'b0, 32'h0, "a5_nopar");
    send(8'h3C, 1'b1, 1'b0, 32'h0, "3c_even");
    send(8'h3C, 1'b1, 1'b1, 32'h0, "3c_odd");
    send(8'hC3, 1'b1, 1'b1, (32'h1 << 3) | (32'h1 << 7), "dv_ignored");
    send_held(8'h00, 8'hFF, 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0, 32'h0, "55_par");

    // reset in the middle of the data phase
    bus.P_Data = 8'h96; bus.Par_En = 1'b1; bus.Par_bit = 1'b0; bus.Data_Valid = 1'b1;
    exp_q.push_back(model(8'h96, 1'b1, 1'b0, -1, "aborted"));
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midrst_tx", 32'(bus.TX_OUT), 32'(1));
    check("midrst_busy", 32'(bus.Busy), 32'(0));
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    send(8'h69, 1'b1, 1'b1, 32'h0, "after_rst");

    for (int i = 0; i < 25; i++) begin
      send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? $urandom : 32'h0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    for (int i = 0; i < 100 && (exp_q.size() != 0 || collecting); i++) @(negedge CLK);
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
